// File: rtl/bg_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// bg_ctrl_pkg
// Shared constants for the background-model frame sequencer:
//   THR_W      - width of the live foreground threshold
//   bg_state_e - sequencer state encoding (SETTLE=0, LOAD=1, RUN=2)
// ---------------------------------------------------------------------------
package bg_ctrl_pkg;

   localparam int THR_W = 9;

   typedef enum logic [1:0] {
      ST_SETTLE = 2'd0,
      ST_LOAD   = 2'd1,
      ST_RUN    = 2'd2
   } bg_state_e;

endpackage

// File: rtl/bg_model_ctrl_if.sv
// ---------------------------------------------------------------------------
// bg_model_ctrl_if
// Control bundle between the frame sequencer and its environment.
//   frame inputs : frame_start, relearn_req, thr_up, thr_down,
//                  fg_valid_in, fg_flag_in
//   datapath outs: datapath_en, load_frame, threshold_out, fg_count_out,
//                  state_out
// modport slave  - the sequencer side (bg_model_ctrl)
// modport master - the driving side (frame timing / buttons / datapath)
// ---------------------------------------------------------------------------
interface bg_model_ctrl_if #(
   parameter int CNT_WIDTH = 17
);
   logic                          frame_start;
   logic                          relearn_req;
   logic                          thr_up;
   logic                          thr_down;
   logic                          fg_valid_in;
   logic                          fg_flag_in;
   logic                          datapath_en;
   logic                          load_frame;
   logic [bg_ctrl_pkg::THR_W-1:0] threshold_out;
   logic [CNT_WIDTH-1:0]          fg_count_out;
   logic [1:0]                    state_out;

   modport slave (
      input  frame_start, relearn_req, thr_up, thr_down, fg_valid_in, fg_flag_in,
      output datapath_en, load_frame, threshold_out, fg_count_out, state_out
   );

   modport master (
      output frame_start, relearn_req, thr_up, thr_down, fg_valid_in, fg_flag_in,
      input  datapath_en, load_frame, threshold_out, fg_count_out, state_out
   );
endinterface

// File: rtl/bg_thr_ctrl.sv
// ---------------------------------------------------------------------------
// bg_thr_ctrl
// Button-driven threshold: a shadow register moves by THR_STEP per pulse,
// clamped to [THR_MIN, THR_MAX]; the live value copies the shadow only on
// frame_start so a frame is never processed with two thresholds.
// Ports:
//   clk, rst      - clock, async active-high reset
//   thr_up/down   - one-cycle button pulses (both at once = no change)
//   frame_start   - frame boundary pulse
//   threshold_out - live threshold (registered)
// ---------------------------------------------------------------------------
module bg_thr_ctrl
   import bg_ctrl_pkg::*;
#(
   parameter int THR_DEFAULT = 30,
   parameter int THR_STEP    = 5,
   parameter int THR_MIN     = 5,
   parameter int THR_MAX     = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             thr_up,
   input  logic             thr_down,
   input  logic             frame_start,
   output logic [THR_W-1:0] threshold_out
);

   localparam logic [THR_W:0]   STEP_X  = (THR_W+1)'(THR_STEP);
   localparam logic [THR_W:0]   MAX_X   = (THR_W+1)'(THR_MAX);
   localparam logic [THR_W:0]   FLOOR_X = (THR_W+1)'(THR_MIN + THR_STEP);
   localparam logic [THR_W-1:0] STEP_N  = THR_W'(THR_STEP);
   localparam logic [THR_W-1:0] MIN_N   = THR_W'(THR_MIN);
   localparam logic [THR_W-1:0] MAX_N   = THR_W'(THR_MAX);
   localparam logic [THR_W-1:0] DEF_N   = THR_W'(THR_DEFAULT);

   logic [THR_W-1:0] shadow_q, shadow_d;
   logic [THR_W-1:0] thr_q, thr_d;
   logic [THR_W:0]   sum;

   // One extra bit on the way up so the clamp sees the overflow instead of a wrap.
   always_comb begin
      shadow_d = shadow_q;
      sum      = {1'b0, shadow_q} + STEP_X;
      if (thr_up && !thr_down) begin
         shadow_d = (sum > MAX_X) ? MAX_N : sum[THR_W-1:0];
      end else if (thr_down && !thr_up) begin
         shadow_d = ({1'b0, shadow_q} < FLOOR_X) ? MIN_N : shadow_q - STEP_N;
      end
      // Old shadow is applied: a pulse on the boundary cycle waits one frame.
      thr_d = frame_start ? shadow_q : thr_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_q <= DEF_N;
         thr_q    <= DEF_N;
      end else begin
         shadow_q <= shadow_d;
         thr_q    <= thr_d;
      end
   end

   assign threshold_out = thr_q;

endmodule

// File: rtl/bg_model_ctrl.sv
// ---------------------------------------------------------------------------
// bg_model_ctrl
// Frame-level sequencer for the adaptive background datapath:
//   SETTLE - ignore SETTLE_FRAMES frame_start pulses after reset
//   LOAD   - one whole frame captured as background (load_frame=1)
//   RUN    - adaptive update; relearn_req (or, with BG_AUTO_RELEARN_EN,
//            RELEARN_FRAMES consecutive frames with more than FG_LIMIT
//            foreground pixels) sends it back to LOAD at the next boundary
// Also counts foreground pixels per frame and owns the live threshold.
// Ports:
//   clk, rst - clock, async active-high reset
//   bus      - bg_model_ctrl_if.slave (frame/button inputs, datapath outputs)
// Optional feature macro: BG_AUTO_RELEARN_EN
// ---------------------------------------------------------------------------
module bg_model_ctrl
   import bg_ctrl_pkg::*;
#(
   parameter int SETTLE_FRAMES  = 4,
   parameter int THR_DEFAULT    = 30,
   parameter int THR_STEP       = 5,
   parameter int THR_MIN        = 5,
   parameter int THR_MAX        = 255,
   parameter int CNT_WIDTH      = 17,
   parameter int FG_LIMIT       = 38400,
   parameter int RELEARN_FRAMES = 8
) (
   input  logic            clk,
   input  logic            rst,
   bg_model_ctrl_if.slave  bus
);

   localparam logic [7:0] SETTLE_N = 8'(SETTLE_FRAMES);

   bg_state_e            state_q, state_d;
   logic [7:0]           settle_cnt_q, settle_cnt_d, settle_inc;
   logic                 relearn_pend_q, relearn_pend_d;
   logic                 load_frame_q, load_frame_d;
   logic                 datapath_en_q, datapath_en_d;
   logic [CNT_WIDTH-1:0] fg_cnt_q, fg_cnt_d;
   logic [CNT_WIDTH-1:0] fg_count_out_q, fg_count_out_d;
   logic                 fg_inc;
   logic                 enter_load;
   logic                 auto_trig;

   assign fg_inc     = bus.fg_valid_in && bus.fg_flag_in;
   assign settle_inc = settle_cnt_q + 8'd1;

   // ---------------- sequencer ----------------
   always_comb begin
      state_d        = state_q;
      settle_cnt_d   = settle_cnt_q;
      relearn_pend_d = relearn_pend_q;
      if (state_q == ST_RUN && bus.relearn_req) relearn_pend_d = 1'b1;
      if (bus.frame_start) begin
         case (state_q)
            ST_SETTLE: begin
               settle_cnt_d = settle_inc;
               if (settle_inc == SETTLE_N) state_d = ST_LOAD;
            end
            ST_LOAD: state_d = ST_RUN;
            ST_RUN: begin
               // relearn_req on the boundary itself acts immediately
               if (relearn_pend_q || bus.relearn_req || auto_trig) state_d = ST_LOAD;
            end
            default: state_d = ST_SETTLE;
         endcase
      end
      enter_load = (state_d == ST_LOAD) && (state_q != ST_LOAD);
      if (enter_load) relearn_pend_d = 1'b0;
      // Outputs registered from the next state so they line up with state_out.
      load_frame_d  = (state_d == ST_LOAD);
      datapath_en_d = (state_d != ST_SETTLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_SETTLE;
         settle_cnt_q   <= '0;
         relearn_pend_q <= 1'b0;
         load_frame_q   <= 1'b0;
         datapath_en_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         settle_cnt_q   <= settle_cnt_d;
         relearn_pend_q <= relearn_pend_d;
         load_frame_q   <= load_frame_d;
         datapath_en_q  <= datapath_en_d;
      end
   end

   // ---------------- foreground counter ----------------
   // A qualified pixel on the boundary cycle belongs to the new frame.
   always_comb begin
      fg_cnt_d       = fg_cnt_q;
      fg_count_out_d = fg_count_out_q;
      if (bus.frame_start) begin
         fg_count_out_d = fg_cnt_q;
         fg_cnt_d       = fg_inc ? CNT_WIDTH'(1) : '0;
      end else if (fg_inc && !(&fg_cnt_q)) begin
         fg_cnt_d = fg_cnt_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fg_cnt_q       <= '0;
         fg_count_out_q <= '0;
      end else begin
         fg_cnt_q       <= fg_cnt_d;
         fg_count_out_q <= fg_count_out_d;
      end
   end

   // ---------------- over-frame tracking ----------------
`ifdef BG_AUTO_RELEARN_EN
   localparam logic [CNT_WIDTH-1:0] FG_LIMIT_N = CNT_WIDTH'(FG_LIMIT);
   localparam logic [7:0]           RELEARN_N  = 8'(RELEARN_FRAMES);

   logic [7:0] over_cnt_q, over_cnt_d, over_eval;

   // Only frames that ran entirely in RUN are judged; the LOAD frame is not.
   always_comb begin
      over_eval = over_cnt_q;
      auto_trig = 1'b0;
      if (bus.frame_start && state_q == ST_RUN) begin
         if (fg_cnt_q > FG_LIMIT_N)
            over_eval = (&over_cnt_q) ? over_cnt_q : over_cnt_q + 8'd1;
         else
            over_eval = '0;
         auto_trig = (over_eval >= RELEARN_N);
      end
   end

   // Kept apart from over_eval so the FSM -> enter_load path is not a loop.
   always_comb begin
      over_cnt_d = enter_load ? 8'd0 : over_eval;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) over_cnt_q <= '0;
      else     over_cnt_q <= over_cnt_d;
   end
`else
   assign auto_trig = 1'b0;
`endif

   // ---------------- threshold ----------------
   bg_thr_ctrl #(
      .THR_DEFAULT (THR_DEFAULT),
      .THR_STEP    (THR_STEP),
      .THR_MIN     (THR_MIN),
      .THR_MAX     (THR_MAX)
   ) u_thr (
      .clk           (clk),
      .rst           (rst),
      .thr_up        (bus.thr_up),
      .thr_down      (bus.thr_down),
      .frame_start   (bus.frame_start),
      .threshold_out (bus.threshold_out)
   );

   assign bus.state_out    = state_q;
   assign bus.load_frame   = load_frame_q;
   assign bus.datapath_en  = datapath_en_q;
   assign bus.fg_count_out = fg_count_out_q;

endmodule
